// File: rtl/tone_period_meter_if.sv
// Tone input and measurement result bundle for tone_period_meter.
// master: the meter (samples toneIn, drives results); slave: the consumer.
interface tone_period_meter_if #(
    parameter int CNT_W = 24
);
    logic             toneIn;
    logic [CNT_W-1:0] periodOut;
    logic             periodValid;
    logic             locked;
    logic             noTone;
    logic             toneMatch;

    modport master (
        input  toneIn,
        output periodOut, periodValid, locked, noTone, toneMatch
    );

    modport slave (
        output toneIn,
        input  periodOut, periodValid, locked, noTone, toneMatch
    );
endinterface

// File: rtl/tone_period_meter.sv
// Measures the rising-edge period of an asynchronous tone in clk cycles, with lock and loss-of-tone flags.
// Optional target-period comparator is enabled by defining TONE_MATCH_EN.
module tone_period_meter #(
    parameter int CNT_W           = 24,
    parameter int maxPeriod       = 4000000,
    parameter int minPeriod       = 1000,
    parameter int tolerance       = 16,
    parameter int stableCount     = 4,
    parameter int targetTimeValue = 101250
) (
    input  logic                clk,
    input  logic                reset,
    tone_period_meter_if.master bus
);
    localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(maxPeriod);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(minPeriod);
    localparam logic [CNT_W-1:0] TOL      = CNT_W'(tolerance);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [3:0]       STABLE_N = 4'(stableCount);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             sync1_r;
    logic             sync2_r;
    logic             sync3_r;
    logic             rise_s;
    logic             accept_s;
    logic             timeout_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] period_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             locked_r;
    logic             locked_nxt_s;
    logic             no_tone_r;
    logic             have_prev_r;
    logic             have_prev_nxt_s;
    logic             match_r;
    logic             match_nxt_s;
    logic [3:0]       run_r;
    logic [3:0]       run_nxt_s;
    logic [3:0]       run_inc_s;

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    // Synchronize toneIn and keep one history flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= bus.toneIn;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign rise_s    = sync2_r & ~sync3_r;
    // A rise that lands exactly on the timeout count still counts as a measurement
    assign accept_s  = (state_r == MEASURE) && rise_s && (cnt_r >= MIN_P);
    assign timeout_s = (state_r == MEASURE) && !accept_s && (cnt_r >= MAX_P);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = MEASURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MEASURE: begin
                if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = MEASURE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of counter, period and stability tracking
    always_comb begin
        cnt_nxt_s       = cnt_r;
        period_nxt_s    = period_r;
        valid_nxt_s     = 1'b0;
        run_nxt_s       = run_r;
        locked_nxt_s    = locked_r;
        have_prev_nxt_s = have_prev_r;
        run_inc_s       = (run_r < STABLE_N) ? (run_r + 4'd1) : STABLE_N;
        case (state_r)
            IDLE: begin
                have_prev_nxt_s = 1'b0;
                run_nxt_s       = 4'd0;
                locked_nxt_s    = 1'b0;
                if (rise_s) begin
                    cnt_nxt_s = CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            MEASURE: begin
                if (accept_s) begin
                    cnt_nxt_s       = CNT_ONE;
                    period_nxt_s    = cnt_r;
                    valid_nxt_s     = 1'b1;
                    have_prev_nxt_s = 1'b1;
                    // First period after IDLE has nothing to compare against
                    if (!have_prev_r) begin
                        run_nxt_s    = 4'd0;
                        locked_nxt_s = 1'b0;
                    end else if (abs_diff(cnt_r, period_r) <= TOL) begin
                        run_nxt_s    = run_inc_s;
                        locked_nxt_s = locked_r | (run_inc_s == STABLE_N);
                    end else begin
                        run_nxt_s    = 4'd0;
                        locked_nxt_s = 1'b0;
                    end
                end else if (timeout_s) begin
                    cnt_nxt_s       = CNT_ZERO;
                    period_nxt_s    = CNT_ZERO;
                    run_nxt_s       = 4'd0;
                    locked_nxt_s    = 1'b0;
                    have_prev_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_nxt_s       = CNT_ZERO;
                period_nxt_s    = CNT_ZERO;
                run_nxt_s       = 4'd0;
                locked_nxt_s    = 1'b0;
                have_prev_nxt_s = 1'b0;
            end
        endcase
    end

`ifdef TONE_MATCH_EN
    localparam logic [CNT_W-1:0] TARGET_P = CNT_W'(2 * (targetTimeValue + 1));
    assign match_nxt_s = locked_nxt_s & (abs_diff(period_nxt_s, TARGET_P) <= TOL);
`else
    assign match_nxt_s = 1'b0;
`endif

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r       <= CNT_ZERO;
            period_r    <= CNT_ZERO;
            valid_r     <= 1'b0;
            run_r       <= 4'd0;
            locked_r    <= 1'b0;
            have_prev_r <= 1'b0;
            no_tone_r   <= 1'b1;
            match_r     <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            period_r    <= period_nxt_s;
            valid_r     <= valid_nxt_s;
            run_r       <= run_nxt_s;
            locked_r    <= locked_nxt_s;
            have_prev_r <= have_prev_nxt_s;
            no_tone_r   <= (state_nxt_s == IDLE);
            match_r     <= match_nxt_s;
        end
    end

    assign bus.periodOut   = period_r;
    assign bus.periodValid = valid_r;
    assign bus.locked      = locked_r;
    assign bus.noTone      = no_tone_r;
    assign bus.toneMatch   = match_r;
endmodule
